// File: rtl/axis_conv_input_slice.sv
// Registered AXI-Stream slice (2-entry skid) in front of the conv engine, with kernel-config
// capture and per-frame beat counting. Define AXIS_CONV_SLICE_STALL_CNT_EN to add stall_cycles.
module axis_conv_input_slice #(
    parameter int UNITS               = 8,
    parameter int CORES               = 4,
    parameter int MEMBERS             = 8,
    parameter int WORD_WIDTH          = 8,
    parameter int TUSER_WIDTH_CONV_IN = 16,
    parameter int I_IS_CONFIG         = 9,
    parameter int I_KERNEL_W_1        = 11,
    parameter int BITS_KERNEL_W       = 2,
    parameter int I_KERNEL_H_1        = 2,
    parameter int BITS_KERNEL_H       = 2,
    parameter int BEAT_CNT_WIDTH      = 16
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tvalid,
    input  logic                                  s_axis_tlast,
    input  logic [TUSER_WIDTH_CONV_IN-1:0]        s_axis_tuser,
    input  logic [WORD_WIDTH*UNITS-1:0]           s_axis_pixels_1_tdata,
    input  logic [WORD_WIDTH*UNITS-1:0]           s_axis_pixels_2_tdata,
    input  logic [WORD_WIDTH*CORES*MEMBERS-1:0]   s_axis_weights_tdata,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    output logic [TUSER_WIDTH_CONV_IN-1:0]        m_axis_tuser,
    output logic [WORD_WIDTH*UNITS-1:0]           m_axis_pixels_1_tdata,
    output logic [WORD_WIDTH*UNITS-1:0]           m_axis_pixels_2_tdata,
    output logic [WORD_WIDTH*CORES*MEMBERS-1:0]   m_axis_weights_tdata,
    output logic [BITS_KERNEL_W-1:0]              cfg_kernel_w_1,
    output logic [BITS_KERNEL_H-1:0]              cfg_kernel_h_1,
    output logic                                  cfg_update,
    output logic                                  frame_done,
    output logic [BEAT_CNT_WIDTH-1:0]             frame_beats
`ifdef AXIS_CONV_SLICE_STALL_CNT_EN
    ,
    output logic [31:0]                           stall_cycles
`endif
);

    localparam int PW = 1 + TUSER_WIDTH_CONV_IN + 2*WORD_WIDTH*UNITS + WORD_WIDTH*CORES*MEMBERS;
    localparam logic [BEAT_CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    logic [PW-1:0] s_payload, main_q, main_d, skid_q, skid_d;
    logic          main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, s_rdy_q;
    logic          s_fire, m_fire;
    state_e        state;

    assign s_payload = {s_axis_tlast, s_axis_tuser, s_axis_pixels_1_tdata,
                        s_axis_pixels_2_tdata, s_axis_weights_tdata};
    assign {m_axis_tlast, m_axis_tuser, m_axis_pixels_1_tdata,
            m_axis_pixels_2_tdata, m_axis_weights_tdata} = main_q;

    assign s_axis_tready = s_rdy_q;
    assign m_axis_tvalid = main_vld_q;
    assign s_fire        = s_axis_tvalid && s_rdy_q;
    assign m_fire        = main_vld_q && m_axis_tready;

    always_comb begin
        if (!main_vld_q)      state = EMPTY;
        else if (!skid_vld_q) state = ONE;
        else                  state = FULL;
    end

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_q;
        skid_d     = skid_q;
        unique case (state)
            EMPTY: begin
                if (s_fire) begin
                    main_d     = s_payload;
                    main_vld_d = 1'b1;
                end
            end
            ONE: begin
                if (s_fire && m_fire) begin
                    main_d = s_payload;
                end else if (s_fire) begin
                    skid_d     = s_payload;
                    skid_vld_d = 1'b1;
                end else if (m_fire) begin
                    main_vld_d = 1'b0;
                end
            end
            FULL: begin
                // s_axis_tready is low here, so only the drain side can move
                if (m_fire) begin
                    main_d     = skid_q;
                    skid_vld_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            s_rdy_q    <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            s_rdy_q    <= !skid_vld_d;
        end
    end

    always_ff @(posedge aclk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    logic [BITS_KERNEL_W-1:0]  kw_q;
    logic [BITS_KERNEL_H-1:0]  kh_q;
    logic                      cfg_upd_q, fdone_q;
    logic [BEAT_CNT_WIDTH-1:0] cnt_q, fbeats_q, cnt_inc;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge aclk) begin
        if (areset) begin
            kw_q      <= '0;
            kh_q      <= '0;
            cfg_upd_q <= 1'b0;
            fdone_q   <= 1'b0;
            cnt_q     <= '0;
            fbeats_q  <= '0;
        end else begin
            cfg_upd_q <= 1'b0;
            fdone_q   <= 1'b0;
            if (m_fire && m_axis_tuser[I_IS_CONFIG]) begin
                kw_q      <= m_axis_tuser[I_KERNEL_W_1 +: BITS_KERNEL_W];
                kh_q      <= m_axis_tuser[I_KERNEL_H_1 +: BITS_KERNEL_H];
                cfg_upd_q <= 1'b1;
            end
            if (m_fire) begin
                if (m_axis_tlast) begin
                    fbeats_q <= cnt_inc;
                    cnt_q    <= '0;
                    fdone_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

    assign cfg_kernel_w_1 = kw_q;
    assign cfg_kernel_h_1 = kh_q;
    assign cfg_update     = cfg_upd_q;
    assign frame_done     = fdone_q;
    assign frame_beats    = fbeats_q;

`ifdef AXIS_CONV_SLICE_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            stall_q <= '0;
        end else if (main_vld_q && !m_axis_tready && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_axis_conv_input_slice.sv
// Bench for axis_conv_input_slice: directed and random valid/ready traffic checked against a
// queue-based occupancy model of the slice, config capture and frame beat counting.
module tb_axis_conv_input_slice;
    localparam int UNITS = 8, CORES = 4, MEMBERS = 8, WW = 8, TUW = 16;
    localparam int I_CFG = 9, I_KW = 11, BKW = 2, I_KH = 2, BKH = 2, BCW = 16;
    localparam int PW = 1 + TUW + 2*WW*UNITS + WW*CORES*MEMBERS;

    logic                        aclk = 1'b0;
    logic                        areset = 1'b1;
    logic                        s_axis_tready, s_axis_tvalid, s_axis_tlast;
    logic [TUW-1:0]              s_axis_tuser;
    logic [WW*UNITS-1:0]         s_axis_pixels_1_tdata, s_axis_pixels_2_tdata;
    logic [WW*CORES*MEMBERS-1:0] s_axis_weights_tdata;
    logic                        m_axis_tready, m_axis_tvalid, m_axis_tlast;
    logic [TUW-1:0]              m_axis_tuser;
    logic [WW*UNITS-1:0]         m_axis_pixels_1_tdata, m_axis_pixels_2_tdata;
    logic [WW*CORES*MEMBERS-1:0] m_axis_weights_tdata;
    logic [BKW-1:0]              cfg_kernel_w_1;
    logic [BKH-1:0]              cfg_kernel_h_1;
    logic                        cfg_update, frame_done;
    logic [BCW-1:0]              frame_beats;
`ifdef AXIS_CONV_SLICE_STALL_CNT_EN
    logic [31:0]                 stall_cycles;
`endif

    axis_conv_input_slice #(
        .UNITS(UNITS), .CORES(CORES), .MEMBERS(MEMBERS), .WORD_WIDTH(WW),
        .TUSER_WIDTH_CONV_IN(TUW), .I_IS_CONFIG(I_CFG), .I_KERNEL_W_1(I_KW),
        .BITS_KERNEL_W(BKW), .I_KERNEL_H_1(I_KH), .BITS_KERNEL_H(BKH), .BEAT_CNT_WIDTH(BCW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_pixels_1_tdata(s_axis_pixels_1_tdata),
        .s_axis_pixels_2_tdata(s_axis_pixels_2_tdata),
        .s_axis_weights_tdata(s_axis_weights_tdata),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_pixels_1_tdata(m_axis_pixels_1_tdata),
        .m_axis_pixels_2_tdata(m_axis_pixels_2_tdata),
        .m_axis_weights_tdata(m_axis_weights_tdata),
        .cfg_kernel_w_1(cfg_kernel_w_1), .cfg_kernel_h_1(cfg_kernel_h_1),
        .cfg_update(cfg_update), .frame_done(frame_done), .frame_beats(frame_beats)
`ifdef AXIS_CONV_SLICE_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 aclk = ~aclk;

    logic [PW-1:0] m_pay;
    assign m_pay = {m_axis_tlast, m_axis_tuser, m_axis_pixels_1_tdata,
                    m_axis_pixels_2_tdata, m_axis_weights_tdata};

    int n_chk = 0, n_err = 0, n_acc = 0;

    // reference model: FIFO of accepted beats (front = what m_* must show) plus sideband state
    logic [PW-1:0] q[$];
    logic          exp_rdy = 1'b0, exp_upd = 1'b0, exp_fd = 1'b0;
    logic [BKW-1:0] exp_kw = '0;
    logic [BKH-1:0] exp_kh = '0;
    logic [BCW-1:0] exp_fb = '0, cnt = '0;
    logic [31:0]    exp_stall = '0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk_beat(input logic last, input logic is_cfg,
                                              input logic [BKW-1:0] kw, input logic [BKH-1:0] kh);
        logic [415:0] r;
        logic [PW-1:0] b;
        logic [TUW-1:0] u;
        for (int i = 0; i < 13; i++) r[i*32 +: 32] = $urandom;
        b = r[PW-1:0];
        u = b[PW-2 -: TUW];
        u[I_CFG] = is_cfg;
        if (is_cfg) begin
            u[I_KW +: BKW] = kw;
            u[I_KH +: BKH] = kh;
        end
        b[PW-2 -: TUW] = u;
        b[PW-1] = last;
        return b;
    endfunction

    function automatic logic [PW-1:0] inc_beat(input int n);
        logic [PW-1:0] b;
        b = '0;
        for (int i = 0; i < PW/16; i++) b[i*16 +: 16] = 16'(n * 64 + i);
        b[PW-2 -: TUW] = 16'(n);
        b[PW-2 - (TUW-1) + I_CFG] = 1'b0;
        b[PW-1] = 1'b0;
        return b;
    endfunction

    task automatic cyc(input logic rst, input logic vld, input logic rdy, input logic [PW-1:0] b);
        logic [PW-1:0] f;
        logic [TUW-1:0] u;
        logic s_fire, m_fire;
        @(negedge aclk);
        chk("m_tvalid", m_axis_tvalid, q.size() > 0);
        chk("s_tready", s_axis_tready, exp_rdy);
        if (q.size() > 0) chk("payload", m_pay, q[0]);
        chk("cfg_w", cfg_kernel_w_1, exp_kw);
        chk("cfg_h", cfg_kernel_h_1, exp_kh);
        chk("cfg_update", cfg_update, exp_upd);
        chk("frame_done", frame_done, exp_fd);
        chk("frame_beats", frame_beats, exp_fb);
`ifdef AXIS_CONV_SLICE_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, exp_stall);
`endif
        areset = rst;
        s_axis_tvalid = vld;
        m_axis_tready = rdy;
        {s_axis_tlast, s_axis_tuser, s_axis_pixels_1_tdata,
         s_axis_pixels_2_tdata, s_axis_weights_tdata} = b;
        if (rst) begin
            q.delete();
            exp_rdy = 1'b0; exp_upd = 1'b0; exp_fd = 1'b0;
            exp_kw = '0; exp_kh = '0; exp_fb = '0; cnt = '0; exp_stall = '0;
        end else begin
            s_fire = vld && exp_rdy;
            m_fire = (q.size() > 0) && rdy;
            exp_upd = 1'b0;
            exp_fd  = 1'b0;
            if (q.size() > 0 && !rdy && exp_stall != 32'hFFFF_FFFF) exp_stall++;
            if (m_fire) begin
                f = q.pop_front();
                u = f[PW-2 -: TUW];
                if (u[I_CFG]) begin
                    exp_kw  = u[I_KW +: BKW];
                    exp_kh  = u[I_KH +: BKH];
                    exp_upd = 1'b1;
                end
                if (f[PW-1]) begin
                    exp_fb = (cnt == '1) ? cnt : cnt + 1'b1;
                    cnt    = '0;
                    exp_fd = 1'b1;
                end else if (cnt != '1) begin
                    cnt++;
                end
            end
            if (s_fire) begin
                q.push_back(b);
                n_acc++;
            end
            exp_rdy = q.size() < 2;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, '0);
    endtask

    initial begin
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        {s_axis_tlast, s_axis_tuser, s_axis_pixels_1_tdata,
         s_axis_pixels_2_tdata, s_axis_weights_tdata} = '0;
        repeat (2) @(posedge aclk);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, '0);

        // streaming at full rate
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1, inc_beat(i + 1));
        drain(3);

        // fill to FULL, stall 3 cycles, release
        cyc(1'b0, 1'b1, 1'b0, mk_beat(1'b0, 1'b0, '0, '0));
        cyc(1'b0, 1'b1, 1'b0, mk_beat(1'b0, 1'b0, '0, '0));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0);
        drain(4);

        // config beat kernel_w-1=2, kernel_h-1=1
        cyc(1'b0, 1'b1, 1'b1, mk_beat(1'b0, 1'b1, 2'd2, 2'd1));
        drain(3);

        // frames of 5 and 1 beats from a clean counter
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, mk_beat(i == 4, 1'b0, '0, '0));
        cyc(1'b0, 1'b1, 1'b1, mk_beat(1'b1, 1'b0, '0, '0));
        drain(3);

        // random valid/ready, 1000 accepted beats
        n_acc = 0;
        for (int c = 0; c < 20000 && n_acc < 1000; c++)
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                mk_beat($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                        2'($urandom), 2'($urandom)));
        chk("rand_accepted", n_acc >= 1000, 1'b1);
        drain(4);

        // reset while FULL, then a fresh 3-beat frame
        cyc(1'b0, 1'b1, 1'b0, mk_beat(1'b0, 1'b0, '0, '0));
        cyc(1'b0, 1'b1, 1'b0, mk_beat(1'b0, 1'b0, '0, '0));
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, mk_beat(1'b0, 1'b0, '0, '0));
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, mk_beat(i == 2, 1'b0, '0, '0));
        drain(4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
